// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR filter types and sizing
package fir_pkg;

  localparam int NUM_TAPS = 41;
  localparam int COEFF_W  = 16;
  localparam int IDX_W    = 6;

  typedef logic [COEFF_W-1:0] coeff_t;
  typedef logic [IDX_W-1:0]   tap_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    FIN  = 2'd3
  } loader_state_e;

  localparam tap_idx_t LAST_IDX  = tap_idx_t'(NUM_TAPS - 1);
  localparam tap_idx_t MAX_COUNT = tap_idx_t'(NUM_TAPS);

  function automatic tap_idx_t next_idx(input tap_idx_t i);
    return (i == LAST_IDX) ? '0 : i + tap_idx_t'(1);
  endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - burst coefficient writer for fir_filter
// Optional trailing-checksum beat: FIR_COEFF_LOADER_CHECKSUM_EN
module fir_coeff_loader
  import fir_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [IDX_W-1:0]   start_idx,
  input  logic [IDX_W-1:0]   count,
  input  logic               s_valid,
  input  logic [COEFF_W-1:0] s_data,
  output logic               s_ready,
  output logic               coeff_update,
  output logic [IDX_W-1:0]   coeff_sel,
  output logic [COEFF_W-1:0] new_coeff,
  output logic               busy,
  output logic               done,
  output logic               err
);

  loader_state_e state_q, state_d;
  tap_idx_t      idx_q, idx_d;
  tap_idx_t      rem_q, rem_d;
  logic          upd_q, upd_d;
  tap_idx_t      sel_q, sel_d;
  coeff_t        data_q, data_d;
  logic          err_q, err_d;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
  coeff_t        sum_q, sum_d;
`endif

  logic cmd_legal;
  assign cmd_legal = (start_idx < MAX_COUNT) && (count != '0) && (count <= MAX_COUNT);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    upd_d   = 1'b0;
    sel_d   = sel_q;
    data_d  = data_q;
    err_d   = 1'b0;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    s_ready = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (cmd_legal) begin
            idx_d   = start_idx;
            rem_d   = count;
            state_d = LOAD;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          upd_d  = 1'b1;
          sel_d  = idx_q;
          data_d = s_data;
          idx_d  = next_idx(idx_q);
          rem_d  = rem_q - tap_idx_t'(1);
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
          sum_d  = sum_q + s_data;
          if (rem_q == tap_idx_t'(1)) state_d = CHK;
`else
          if (rem_q == tap_idx_t'(1)) state_d = FIN;
`endif
        end
      end
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
      CHK: begin
        // Trailing beat is compared only, never written to the filter
        s_ready = 1'b1;
        if (s_valid) begin
          err_d   = (s_data != sum_q);
          state_d = FIN;
        end
      end
`endif
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      upd_q   <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      upd_q   <= upd_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign coeff_update = upd_q;
  assign coeff_sel    = sel_q;
  assign new_coeff    = data_q;
  assign err          = err_q;

endmodule
